// File: rtl/wb_port_pkg.sv
`default_nettype none
// ============================================================================
// Package  : wb_port_pkg
// Brief    : Shared constants, register map and bus FSM states for the
//            Caravel user-port Wishbone responder.
// Revision : 1.0 - initial release
// ============================================================================
package wb_port_pkg;

  // Register word index taken from adr[4:2]
  localparam logic [2:0] REG_ID       = 3'd0;
  localparam logic [2:0] REG_CTRL     = 3'd1;
  localparam logic [2:0] REG_GPIO_OUT = 3'd2;
  localparam logic [2:0] REG_GPIO_OE  = 3'd3;
  localparam logic [2:0] REG_COUNT    = 3'd4;
  localparam logic [2:0] REG_COMPARE  = 3'd5;
  localparam logic [2:0] REG_STATUS   = 3'd6;
  localparam logic [2:0] REG_SCRATCH  = 3'd7;

  // CTRL / STATUS bit positions
  localparam int CTRL_COUNT_EN   = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam int CTRL_COUNT_CLR  = 2;
  localparam int STATUS_IRQ_PEND = 0;

  localparam logic [31:0] DEFAULT_ID   = 32'h5742_0001;
  localparam logic [31:0] DEFAULT_BASE = 32'h3000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_e;

  // Replace only the byte lanes whose select bit is set
  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_responder_if.sv
`default_nettype none
// ============================================================================
// Interface: wb_port_responder_if
// Brief    : Wishbone B4 classic slave-side signal bundle (user project port).
// Revision : 1.0 - initial release
// ============================================================================
interface wb_port_responder_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_timer.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_timer
// Brief    : Free-running 32-bit counter with synchronous clear, compare match
//            and a sticky, write-1-to-clear pending flag.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        count_en_i,
  input  logic        count_clr_i,
  input  logic        irq_w1c_i,
  input  logic [31:0] compare_i,
  output logic [31:0] count_o,
  output logic        irq_pending_o
);

  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        step_hit;

  // Next count and pending: clear beats increment, a new match beats W1C
  always_comb begin
    count_d  = count_q;
    step_hit = 1'b0;
    if (count_clr_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      count_d  = count_q + 32'd1;
      step_hit = (count_d == compare_i);
    end
    pend_d = step_hit | (pend_q & ~irq_w1c_i);
  end

  // Counter and pending flag state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  assign count_o       = count_q;
  assign irq_pending_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/wb_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_responder
// Brief    : Wishbone B4 classic slave for the Caravel user port. ID, control,
//            timer with compare interrupt, scratch and GPIO out/enable regs.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_responder
  import wb_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID,
  parameter int          WAIT_STATES = 0,
  parameter int          IO_W        = 32
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_port_responder_if.slave  wbs,
  output logic [IO_W-1:0]     io_out,
  output logic [IO_W-1:0]     io_oeb,
  output logic                irq
);

  localparam bit          NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] GPIO_MASK = (IO_W >= 32) ? 32'hFFFF_FFFF
                                                   : 32'((64'd1 << IO_W) - 64'd1);

  bus_state_e  state_q;
  logic [3:0]  wait_q;
  logic        ack_q;
  logic [31:0] dat_q;

  logic [1:0]  ctrl_q;
  logic [31:0] gpio_out_q;
  logic [31:0] gpio_oe_q;
  logic [31:0] compare_q;
  logic [31:0] scratch_q;

  logic        w_req, w_hit, w_in_map, w_go_ack, w_commit;
  logic        w_clr, w_w1c;
  logic [2:0]  w_idx;
  logic [31:0] w_rd_data, w_count;
  logic        w_pend;
  logic        w_unused_adr;

  assign w_req    = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign w_hit    = w_req & (wbs.wbs_adr_i[31:16] == BASE_ADDR[31:16]);
  // Only the first eight words are backed; the rest of the window reads 0
  assign w_in_map = (wbs.wbs_adr_i[15:5] == 11'd0);
  assign w_idx    = wbs.wbs_adr_i[4:2];
  assign w_unused_adr = ^wbs.wbs_adr_i[1:0];

  // Edge on which ack rises; writes commit on this same edge
  assign w_go_ack = ((state_q == ST_IDLE) && w_hit && !ack_q && NO_WAIT) ||
                    ((state_q == ST_WAIT) && w_req && (wait_q == 4'd0));
  assign w_commit = w_go_ack & wbs.wbs_we_i & w_in_map;

  assign w_clr = w_commit && (w_idx == REG_CTRL) && wbs.wbs_sel_i[0] &&
                 wbs.wbs_dat_i[CTRL_COUNT_CLR];
  assign w_w1c = w_commit && (w_idx == REG_STATUS) && wbs.wbs_sel_i[0] &&
                 wbs.wbs_dat_i[STATUS_IRQ_PEND];

  // Read multiplexer over the register map
  always_comb begin
    w_rd_data = '0;
    if (w_in_map) begin
      case (w_idx)
        REG_ID:       w_rd_data = ID_VALUE;
        REG_CTRL:     w_rd_data = {30'd0, ctrl_q};
        REG_GPIO_OUT: w_rd_data = gpio_out_q;
        REG_GPIO_OE:  w_rd_data = gpio_oe_q;
        REG_COUNT:    w_rd_data = w_count;
        REG_COMPARE:  w_rd_data = compare_q;
        REG_STATUS:   w_rd_data = {31'd0, w_pend};
        REG_SCRATCH:  w_rd_data = scratch_q;
        default:      w_rd_data = '0;
      endcase
    end
  end

  // Bus FSM with registered ack and read data
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          dat_q <= '0;
          if (w_go_ack) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            dat_q   <= wbs.wbs_we_i ? 32'd0 : w_rd_data;
          end else if (w_hit && !ack_q) begin
            state_q <= ST_WAIT;
            wait_q  <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (!w_req) begin
            state_q <= ST_IDLE;
          end else if (w_go_ack) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            dat_q   <= wbs.wbs_we_i ? 32'd0 : w_rd_data;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          dat_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          dat_q   <= '0;
        end
      endcase
    end
  end

  // Register writes, lane-masked, committed as ack rises
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_q     <= '0;
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
      compare_q  <= '0;
      scratch_q  <= '0;
    end else if (w_commit) begin
      case (w_idx)
        REG_CTRL: begin
          if (wbs.wbs_sel_i[0]) begin
            ctrl_q[CTRL_COUNT_EN] <= wbs.wbs_dat_i[CTRL_COUNT_EN];
            ctrl_q[CTRL_IRQ_EN]   <= wbs.wbs_dat_i[CTRL_IRQ_EN];
          end
        end
        REG_GPIO_OUT: gpio_out_q <= merge_lanes(gpio_out_q, wbs.wbs_dat_i, wbs.wbs_sel_i) & GPIO_MASK;
        REG_GPIO_OE:  gpio_oe_q  <= merge_lanes(gpio_oe_q,  wbs.wbs_dat_i, wbs.wbs_sel_i) & GPIO_MASK;
        REG_COMPARE:  compare_q  <= merge_lanes(compare_q,  wbs.wbs_dat_i, wbs.wbs_sel_i);
        REG_SCRATCH:  scratch_q  <= merge_lanes(scratch_q,  wbs.wbs_dat_i, wbs.wbs_sel_i);
        default: ;
      endcase
    end
  end

  wb_port_timer u_timer (
    .clk_i         (wb_clk_i),
    .rst_i         (wb_rst_i),
    .count_en_i    (ctrl_q[CTRL_COUNT_EN]),
    .count_clr_i   (w_clr),
    .irq_w1c_i     (w_w1c),
    .compare_i     (compare_q),
    .count_o       (w_count),
    .irq_pending_o (w_pend)
  );

  assign irq           = w_pend & ctrl_q[CTRL_IRQ_EN];
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

  // Pads above the 32-bit register width are held low and undriven
  if (IO_W > 32) begin : g_io_wide
    assign io_out = {{(IO_W-32){1'b0}}, gpio_out_q};
    assign io_oeb = {{(IO_W-32){1'b1}}, ~gpio_oe_q};
  end else begin : g_io_narrow
    assign io_out = gpio_out_q[IO_W-1:0];
    assign io_oeb = ~gpio_oe_q[IO_W-1:0];
  end

endmodule
`default_nettype wire
